// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO register pair.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic        sign_q;
    logic        sign_r;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc;

    logic [32:0] mul_sum;
    logic [33:0] div_trial;
    logic [63:0] acc_next;
    logic [63:0] product;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        magnitude = (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] apply_sign32(input logic [31:0] v, input logic neg);
        apply_sign32 = neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] apply_sign64(input logic [63:0] v, input logic neg);
        apply_sign64 = neg ? (~v + 64'd1) : v;
    endfunction

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
        div_trial = {1'b0, acc[63:31]} - {2'b00, b_mag};
        if (op_r[1]) begin
            acc_next = div_trial[33] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        product = {32'd0, a_mag} * {32'd0, b_mag};
`else
        product = acc;
`endif
        if (op_r[1]) begin
            // Remainder of a zero divide is the dividend itself, restored to a's sign.
            res_lo = b_zero ? 32'hFFFF_FFFF : apply_sign32(acc[31:0], sign_q);
            res_hi = apply_sign32(acc[63:32], sign_r);
        end else begin
            {res_hi, res_lo} = apply_sign64(product, sign_q);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_r   <= op;
            a_mag  <= magnitude(a, op[0]);
            b_mag  <= magnitude(b, op[0]);
            sign_q <= op[0] & (a[31] ^ b[31]);
            sign_r <= op[0] & a[31];
            b_zero <= (b == 32'd0);
            acc    <= {32'd0, op[1] ? magnitude(a, op[0]) : magnitude(b, op[0])};
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= 5'd0;
                        busy <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state <= op[1] ? CALC : FIX;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= op_r[1] & b_zero;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A computed result takes priority over a coincident MTHI/MTLO.
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results queued at issue, compared on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [64:0] sb[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int     sx, sy;
        longint lx, ly, p;
        logic [63:0] u;
        sx = x; sy = y; lx = sx; ly = sy;
        case (o)
            2'b00: begin u = {32'd0, x} * {32'd0, y}; model = {1'b0, u}; end
            2'b01: begin p = lx * ly; u = p; model = {1'b0, u}; end
            2'b10: model = (y == 32'd0) ? {1'b1, x, 32'hFFFF_FFFF} : {1'b0, x % y, x / y};
            default: begin
                if (y == 32'd0) model = {1'b1, x, 32'hFFFF_FFFF};
                else begin
                    p = lx / ly; u[31:0] = p[31:0];
                    p = lx % ly; u[63:32] = p[31:0];
                    model = {1'b0, u};
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        sb.push_back(model(o, x, y));
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        bit busy_ok = 1'b1;
        logic [64:0] exp;
        while (!done && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_latency"}, cyc - t0, lat);
        check({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        exp = (sb.size() > 0) ? sb.pop_front() : 65'd0;
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        check({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, exp[64]});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        bit saw_done;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // MTHI in IDLE
        @(negedge clk); wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1; wr_hi = 1'b0;
        check("mthi_idle", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("multu_max", MUL_LAT);
        issue(2'b01, 32'hFFFF_FFF9, 32'd3);         wait_done("mult_neg", MUL_LAT);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000); wait_done("mult_minmin", MUL_LAT);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_done("div_neg", DIV_LAT);
        issue(2'b10, 32'd100, 32'd7);               wait_done("divu_100_7", DIV_LAT);
        issue(2'b10, 32'h1234_5678, 32'd0);         wait_done("divu_zero", DIV_LAT);
        issue(2'b11, 32'h8765_4321, 32'd0);         wait_done("div_zero_s", DIV_LAT);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", DIV_LAT);
        issue(2'b11, 32'd1000, 32'hFFFF_FFFD);      wait_done("div_pos_neg", DIV_LAT);

        // Ignored start mid-operation and MTLO during CALC
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk); op = 2'b00; a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); wr_lo = 1'b1; wdata = 32'd5;
        @(posedge clk); #1; wr_lo = 1'b0;
        check("mtlo_calc", {32'd0, lo}, 64'd5);
        check("mtlo_calc_busy", {63'd0, busy}, 64'd1);
        wait_done("divu_busy_start", DIV_LAT);

        // Asynchronous reset in the middle of a divide
        issue(2'b11, 32'hFFFF_FF9C, 32'd7);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        void'(sb.pop_back());
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", {63'd0, saw_done}, 64'd0);

        issue(2'b00, 32'd3, 32'd4); wait_done("multu_3x4", MUL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
